// File: rtl/ram_pkg.sv
// Shared encodings for the sized, wait-stated byte RAM: access sizes,
// read/write direction and the handshake state machine.
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int WS_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/ram_byte_array.sv
// 2**ADDR_W x 8 byte storage with four lane ports covering base..base+3.
// Lane i of rd_data/wr_data is the byte at base+i; addresses wrap modulo depth.
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        wr_en,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  logic [7:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0] lane_addr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi]          = base + ADDR_W'(gi);
    assign rd_data[8*gi +: 8]     = mem[lane_addr[gi]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) mem[lane_addr[i]] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_sized_ws.sv
// Big-endian sized RAM with MOV/MOC/MOCoff handshake and programmable wait states.
// Define RAM_MISALIGN_FAULT_EN to fault misaligned halfword/word accesses.
module ram_sized_ws
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MOV,
  input  logic        ReadWrite,
  input  logic [2:0]  MS_2_0,
  input  logic [31:0] DataIn,
  input  logic [31:0] Address,
  input  logic        MOCoff,
  output logic        MOC,
  output logic [31:0] DataOut,
  output logic        Fault
);

  localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);

  state_t            state_reg, state_next;
  logic [WS_W-1:0]   cnt_reg;
  logic              rw_reg, sext_reg, fault_pend_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [31:0]       din_reg;

  logic              accept, complete;
  logic              fault_now, misalign;
  logic [ADDR_W-1:0] base_now;
  logic [3:0]        lane_en;
  logic [31:0]       lane_wdata, lane_rdata, rd_word;

  // ---- request decode on the live inputs (only used at accept) ----
  `ifdef RAM_MISALIGN_FAULT_EN
  assign misalign = ((MS_2_0[1:0] == SZ_HALF) && Address[0]) ||
                    ((MS_2_0[1:0] == SZ_WORD) && (Address[1:0] != 2'b00));
  `else
  assign misalign = 1'b0;
  `endif

  assign fault_now = (|Address[31:ADDR_W]) || (MS_2_0[1:0] == SZ_RSVD) || misalign;

  // Legacy alignment: misaligned accesses silently drop the low address bits.
  always_comb begin
    base_now = Address[ADDR_W-1:0];
    case (MS_2_0[1:0])
      SZ_HALF: base_now[0]   = 1'b0;
      SZ_WORD: base_now[1:0] = 2'b00;
      default: ;
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (MOV) state_next = BUSY;
      BUSY:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (MOCoff) state_next = MOV ? RELEASE : IDLE;
      RELEASE: if (!MOV) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    MOC      = (state_reg == DONE);
    accept   = (state_reg == IDLE) && MOV;
    complete = (state_reg == BUSY) && (cnt_reg == '0);
  end

  // ---- request latch and wait counter ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg        <= '0;
      rw_reg         <= RW_READ;
      sext_reg       <= 1'b0;
      size_reg       <= SZ_BYTE;
      base_reg       <= '0;
      din_reg        <= '0;
      fault_pend_reg <= 1'b0;
    end else if (accept) begin
      cnt_reg        <= WS_INIT;
      rw_reg         <= ReadWrite;
      sext_reg       <= MS_2_0[2];
      size_reg       <= MS_2_0[1:0];
      base_reg       <= base_now;
      din_reg        <= DataIn;
      fault_pend_reg <= fault_now;
    end else if ((state_reg == BUSY) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // ---- lane steering: lane 0 is the byte at the base address (most significant) ----
  always_comb begin
    lane_en    = 4'b0000;
    lane_wdata = '0;
    rd_word    = {24'h0, lane_rdata[7:0]};
    case (size_reg)
      SZ_WORD: begin
        lane_en    = 4'b1111;
        lane_wdata = {din_reg[7:0], din_reg[15:8], din_reg[23:16], din_reg[31:24]};
        rd_word    = {lane_rdata[7:0], lane_rdata[15:8], lane_rdata[23:16], lane_rdata[31:24]};
      end
      SZ_HALF: begin
        lane_en    = 4'b0011;
        lane_wdata = {16'h0, din_reg[7:0], din_reg[15:8]};
        rd_word    = {{16{sext_reg & lane_rdata[7]}}, lane_rdata[7:0], lane_rdata[15:8]};
      end
      default: begin
        lane_en    = 4'b0001;
        lane_wdata = {24'h0, din_reg[7:0]};
        rd_word    = {{24{sext_reg & lane_rdata[7]}}, lane_rdata[7:0]};
      end
    endcase
    if (!(complete && (rw_reg == RW_WRITE) && !fault_pend_reg)) lane_en = 4'b0000;
  end

  ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (Clk),
    .base    (base_reg),
    .wr_en   (lane_en),
    .wr_data (lane_wdata),
    .rd_data (lane_rdata)
  );

  // ---- completion outputs ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DataOut <= '0;
      Fault   <= 1'b0;
    end else if (complete) begin
      Fault <= fault_pend_reg;
      if ((rw_reg == RW_READ) && !fault_pend_reg) DataOut <= rd_word;
    end else if ((state_reg == DONE) && MOCoff) begin
      Fault <= 1'b0;
    end
  end

endmodule
